morse_symbol_timer: RTL and testbench

//   Upstream front end of the Morse letter decoder. Times on/off intervals of a

---
 rtl/morse_symbol_timer.sv | 175 +++++++++++++++++
 tb/tb_morse_symbol_timer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_symbol_timer.sv
// Morse key interval timer: classifies key on/off intervals into DIT/DAH/GAP/SPACE codes.
// Optional debounce front end enabled by defining MORSE_DEBOUNCE_EN.
module morse_symbol_timer #(
  parameter int UNIT_CYCLES = 4,
  parameter int CNT_W       = 6,
  parameter int DEB_CYCLES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  output logic [2:0] symbol,
  output logic       strobe,
  output logic       keying
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_SIL   = 2'd2,
    ST_LGAP  = 2'd3
  } state_e;

  localparam logic [2:0] SYM_WAIT  = 3'd0;
  localparam logic [2:0] SYM_DIT   = 3'd1;
  localparam logic [2:0] SYM_DAH   = 3'd2;
  localparam logic [2:0] SYM_GAP   = 3'd3;
  localparam logic [2:0] SYM_SPACE = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DAH_MIN   = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_CNT   = CNT_W'(3 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] SPACE_CNT = CNT_W'(7 * UNIT_CYCLES);

  if (UNIT_CYCLES < 1 || DEB_CYCLES < 1 || (7 * UNIT_CYCLES) >= (1 << CNT_W)) begin : g_bad_param
    $error("morse_symbol_timer: illegal UNIT_CYCLES/CNT_W/DEB_CYCLES combination");
  end

  logic key_s;

`ifdef MORSE_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_ZERO = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0] DEB_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             filt_r;
  logic [DEB_W-1:0] deb_cnt_r;

  // Synchronizer plus filter: output flips only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      filt_r    <= 1'b0;
      deb_cnt_r <= DEB_ZERO;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      if (sync2_r != filt_r) begin
        if (deb_cnt_r == DEB_LAST) begin
          filt_r    <= sync2_r;
          deb_cnt_r <= DEB_ZERO;
        end else begin
          deb_cnt_r <= deb_cnt_r + DEB_ONE;
        end
      end else begin
        deb_cnt_r <= DEB_ZERO;
      end
    end
  end

  assign key_s = filt_r;
`else
  assign key_s = key;
`endif

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] press_cnt_r;
  logic [CNT_W-1:0] press_cnt_s;
  logic [CNT_W-1:0] sil_cnt_r;
  logic [CNT_W-1:0] sil_cnt_s;
  logic [2:0]       symbol_s;

  // Next-state, counter and symbol decode; a key press always wins over a silence threshold.
  always_comb begin
    state_s     = state_r;
    press_cnt_s = press_cnt_r;
    sil_cnt_s   = sil_cnt_r;
    symbol_s    = SYM_WAIT;
    case (state_r)
      ST_IDLE: begin
        if (key_s) begin
          state_s     = ST_PRESS;
          press_cnt_s = CNT_ONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (key_s) begin
          if (press_cnt_r < DAH_MIN) begin
            press_cnt_s = press_cnt_r + CNT_ONE;
          end else begin
            press_cnt_s = press_cnt_r;
          end
        end else begin
          if (press_cnt_r < DAH_MIN) begin
            symbol_s = SYM_DIT;
          end else begin
            symbol_s = SYM_DAH;
          end
          state_s   = ST_SIL;
          sil_cnt_s = CNT_ONE;
        end
      end
      ST_SIL: begin
        if (key_s) begin
          state_s     = ST_PRESS;
          press_cnt_s = CNT_ONE;
        end else begin
          sil_cnt_s = sil_cnt_r + CNT_ONE;
          if (sil_cnt_s == GAP_CNT) begin
            symbol_s = SYM_GAP;
            state_s  = ST_LGAP;
          end else begin
            state_s = ST_SIL;
          end
        end
      end
      ST_LGAP: begin
        if (key_s) begin
          state_s     = ST_PRESS;
          press_cnt_s = CNT_ONE;
        end else begin
          sil_cnt_s = sil_cnt_r + CNT_ONE;
          if (sil_cnt_s == SPACE_CNT) begin
            symbol_s = SYM_SPACE;
            state_s  = ST_IDLE;
          end else begin
            state_s = ST_LGAP;
          end
        end
      end
      default: begin
        state_s     = ST_IDLE;
        press_cnt_s = CNT_ZERO;
        sil_cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      press_cnt_r <= CNT_ZERO;
      sil_cnt_r   <= CNT_ZERO;
      symbol      <= SYM_WAIT;
      strobe      <= 1'b0;
      keying      <= 1'b0;
    end else begin
      state_r     <= state_s;
      press_cnt_r <= press_cnt_s;
      sil_cnt_r   <= sil_cnt_s;
      symbol      <= symbol_s;
      strobe      <= (symbol_s != SYM_WAIT);
      keying      <= (state_s == ST_PRESS);
    end
  end

endmodule

// File: tb/tb_morse_symbol_timer.sv
// Directed self-checking bench for morse_symbol_timer (UNIT_CYCLES=4, no debounce).
module tb_morse_symbol_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic [2:0] symbol;
  logic       strobe;
  logic       keying;

  int tests_run = 0;
  int tests_failed = 0;

  morse_symbol_timer #(.UNIT_CYCLES(4), .CNT_W(6), .DEB_CYCLES(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .key    (key),
    .symbol (symbol),
    .strobe (strobe),
    .keying (keying)
  );

  always #5 clk = ~clk;

  // One rising edge; outputs then reflect that edge and new inputs may be applied.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_key(input logic level, input int n);
    key = level;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key   = 1'b0;
    hold_key(1'b0, 3);
    tests_run++;
    if (symbol !== 3'd0 || strobe !== 1'b0 || keying !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got sym=%0d stb=%0b key=%0b required 0/0/0", symbol, strobe, keying);
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      tests_run++;
      if (symbol !== 3'd0 || strobe !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_quiet cycle %0d: got sym=%0d stb=%0b required 0/0", i, symbol, strobe);
      end
    end
  endtask

  task automatic test_dit_gap_space();
    logic [2:0] exp_sym;
    hold_key(1'b1, 3);
    tests_run++;
    if (keying !== 1'b1) begin
      tests_failed++;
      $display("FAIL keying_press: got %0b required 1", keying);
    end
    key = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      exp_sym = (e == 1) ? 3'd1 : (e == 12) ? 3'd3 : (e == 28) ? 3'd4 : 3'd0;
      tests_run++;
      if (symbol !== exp_sym || strobe !== (exp_sym != 3'd0) || keying !== 1'b0) begin
        tests_failed++;
        $display("FAIL silence_edge %0d: got sym=%0d stb=%0b keying=%0b required sym=%0d", e, symbol, strobe, keying, exp_sym);
      end
    end
  endtask

  task automatic test_press_lengths();
    int         lens[3] = '{7, 8, 100};
    logic [2:0] exps[3] = '{3'd1, 3'd2, 3'd2};
    for (int t = 0; t < 3; t++) begin
      key = 1'b1;
      for (int i = 0; i < lens[t]; i++) begin
        tick();
        tests_run++;
        if (symbol !== 3'd0 || keying !== 1'b1) begin
          tests_failed++;
          $display("FAIL press_%0d edge %0d: got sym=%0d keying=%0b required 0/1", lens[t], i, symbol, keying);
        end
      end
      key = 1'b0;
      tick();
      tests_run++;
      if (symbol !== exps[t] || strobe !== 1'b1) begin
        tests_failed++;
        $display("FAIL release_%0d: got sym=%0d stb=%0b required %0d/1", lens[t], symbol, strobe, exps[t]);
      end
      hold_key(1'b0, 30);
    end
  endtask

  task automatic test_back_to_back();
    hold_key(1'b1, 2);
    key = 1'b0;
    tick();
    tests_run++;
    if (symbol !== 3'd1) begin
      tests_failed++;
      $display("FAIL b2b_dit: got %0d required 1", symbol);
    end
    hold_key(1'b0, 4);
    key = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (symbol !== 3'd0) begin
        tests_failed++;
        $display("FAIL b2b_no_gap edge %0d: got %0d required 0", i, symbol);
      end
    end
    key = 1'b0;
    tick();
    tests_run++;
    if (symbol !== 3'd2) begin
      tests_failed++;
      $display("FAIL b2b_dah: got %0d required 2", symbol);
    end
    for (int e = 2; e <= 12; e++) begin
      tick();
      tests_run++;
      if (symbol !== ((e == 12) ? 3'd3 : 3'd0)) begin
        tests_failed++;
        $display("FAIL b2b_gap edge %0d: got %0d required %0d", e, symbol, (e == 12) ? 3 : 0);
      end
    end
    hold_key(1'b0, 20);
  endtask

  task automatic test_silence_boundaries();
    // 11 silent edges, then a press: no GAP at any point.
    hold_key(1'b1, 3);
    key = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      tests_run++;
      if (symbol !== ((e == 1) ? 3'd1 : 3'd0)) begin
        tests_failed++;
        $display("FAIL sil11 edge %0d: got %0d required %0d", e, symbol, (e == 1) ? 1 : 0);
      end
    end
    key = 1'b1;
    tick();
    tests_run++;
    if (symbol !== 3'd0 || keying !== 1'b1) begin
      tests_failed++;
      $display("FAIL sil11_press: got sym=%0d keying=%0b required 0/1", symbol, keying);
    end
    hold_key(1'b1, 2);
    // 12 silent edges, then a press: GAP but no SPACE.
    key = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      tests_run++;
      if (symbol !== ((e == 1) ? 3'd1 : (e == 12) ? 3'd3 : 3'd0)) begin
        tests_failed++;
        $display("FAIL sil12 edge %0d: got %0d", e, symbol);
      end
    end
    key = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (symbol !== 3'd0 || keying !== 1'b1) begin
        tests_failed++;
        $display("FAIL sil12_no_space edge %0d: got sym=%0d keying=%0b required 0/1", i, symbol, keying);
      end
    end
    key = 1'b0;
    tick();
    tests_run++;
    if (symbol !== 3'd2) begin
      tests_failed++;
      $display("FAIL sil12_dah: got %0d required 2", symbol);
    end
    hold_key(1'b0, 30);
  endtask

  task automatic test_reset_mid_press();
    hold_key(1'b1, 14);
    reset = 1'b1;
    tick();
    tests_run++;
    if (symbol !== 3'd0 || strobe !== 1'b0 || keying !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_press: got sym=%0d stb=%0b keying=%0b required 0/0/0", symbol, strobe, keying);
    end
    reset = 1'b0;
    key   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      tests_run++;
      if (symbol !== 3'd0 || keying !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_discard edge %0d: got sym=%0d keying=%0b required 0/0", i, symbol, keying);
      end
    end
    // Key held through reset release starts a fresh press.
    key   = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if (keying !== 1'b1) begin
      tests_failed++;
      $display("FAIL held_through_reset: got keying=%0b required 1", keying);
    end
    hold_key(1'b1, 2);
    key = 1'b0;
    tick();
    tests_run++;
    if (symbol !== 3'd1) begin
      tests_failed++;
      $display("FAIL held_through_reset_dit: got %0d required 1", symbol);
    end
  endtask

  initial begin
    reset = 1'b1;
    key   = 1'b0;
    test_reset();
    test_dit_gap_space();
    test_press_lengths();
    test_back_to_back();
    test_silence_boundaries();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
